// File: rtl/pwm_drv_pkg.sv
// Shared state encoding, default constants and helpers for pwm_duty_ramp_driver.
package pwm_drv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        RAMP_DN,
        HOLD
    } drv_state_t;

    localparam int DEF_CNT_W     = 8;
    localparam int DEF_PRESC_DIV = 40;
    localparam int DEF_SLEW_PER  = 4;
    localparam int DEF_STEP      = 16;
    localparam int DEF_DUTY_30   = 77;
    localparam int DEF_DUTY_50   = 128;
    localparam int DEF_DEAD_CYC  = 4;

    // Full-scale duty for a given counter width; also the 100 % target.
    function automatic int max_duty(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

    // True when two or more of the three level flags are raised together.
    function automatic logic multi_flag(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Counter width that can hold 0..n-1 without collapsing to zero bits.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_deadtime_gen.sv
// Complementary high/low drive from one PWM bit with a fixed both-low gap after every edge.
// Only instantiated when the DEADTIME_EN macro is defined.
module pwm_deadtime_gen
    import pwm_drv_pkg::*;
#(
    parameter int DEAD_CYC = DEF_DEAD_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_pwm,
    output logic o_hi,
    output logic o_lo
);

    localparam int DW = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;

    logic          r_prev;
    logic [DW-1:0] r_cnt;
    logic          r_hi;
    logic          r_lo;

    // Any edge reloads the gap counter, so a pulse shorter than the gap never reaches its side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
            r_cnt  <= '0;
            r_hi   <= 1'b0;
            r_lo   <= 1'b0;
        end else if (i_clr) begin
            r_prev <= 1'b0;
            r_cnt  <= '0;
            r_hi   <= 1'b0;
            r_lo   <= 1'b0;
        end else begin
            r_prev <= i_pwm;
            if (i_pwm != r_prev) begin
                r_cnt <= DW'(DEAD_CYC);
                r_hi  <= 1'b0;
                r_lo  <= 1'b0;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - DW'(1);
                r_hi  <= 1'b0;
                r_lo  <= 1'b0;
            end else begin
                r_hi  <= i_pwm;
                r_lo  <= ~i_pwm;
            end
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/pwm_duty_ramp_driver.sv
// Slew-limited PWM motor drive fed by the soft-start level flags; duty only moves at period ends.
// Optional complementary low-side drive with dead time when DEADTIME_EN is defined.
module pwm_duty_ramp_driver
    import pwm_drv_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int PRESC_DIV = DEF_PRESC_DIV,
    parameter int SLEW_PER  = DEF_SLEW_PER,
    parameter int STEP      = DEF_STEP,
    parameter int DUTY_30   = DEF_DUTY_30,
    parameter int DUTY_50   = DEF_DUTY_50,
    parameter int DEAD_CYC  = DEF_DEAD_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             lvl_30,
    input  logic             lvl_50,
    input  logic             lvl_100,
    output logic             pwm_hi,
    output logic             pwm_lo,
    output logic [CNT_W-1:0] duty_cur,
    output logic             busy,
    output logic             fault_multi
);

    localparam int MAX     = max_duty(CNT_W);
    localparam int PRESC_W = cnt_width(PRESC_DIV);
    localparam int SLEW_W  = cnt_width(SLEW_PER);

    logic [PRESC_W-1:0] r_presc;
    logic [CNT_W-1:0]   r_pwm_cnt;
    logic [SLEW_W-1:0]  r_slew;
    logic [CNT_W-1:0]   r_duty;
    drv_state_t         r_state;
    logic               r_pwm_hi;
    logic               r_fault;

    logic               w_tick;
    logic               w_period_end;
    logic               w_step;
    logic [CNT_W-1:0]   w_target;
    logic [CNT_W:0]     w_duty_x;
    logic [CNT_W:0]     w_target_x;
    logic [CNT_W:0]     w_up_sum;
    logic [CNT_W:0]     w_up_sat;
    logic [CNT_W:0]     w_up_clamp;
    logic [CNT_W:0]     w_dn_diff;
    logic [CNT_W:0]     w_dn_clamp;
    logic [CNT_W-1:0]   w_duty_next;

    // Highest raised level wins; fault reporting is separate and never blocks the drive.
    always_comb begin
        w_target = '0;
        if (lvl_100) begin
            w_target = CNT_W'(MAX);
        end else if (lvl_50) begin
            w_target = CNT_W'(DUTY_50);
        end else if (lvl_30) begin
            w_target = CNT_W'(DUTY_30);
        end
    end

    assign w_tick       = (r_presc == PRESC_W'(PRESC_DIV - 1));
    assign w_period_end = w_tick && (r_pwm_cnt == CNT_W'(MAX - 1));
    assign w_step       = w_period_end && (r_slew == SLEW_W'(SLEW_PER - 1));

    // Prescaler, PWM counter and slew counter all restart from zero when the block is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc   <= '0;
            r_pwm_cnt <= '0;
            r_slew    <= '0;
        end else if (!ena) begin
            r_presc   <= '0;
            r_pwm_cnt <= '0;
            r_slew    <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
            if (w_tick) begin
                r_pwm_cnt <= (r_pwm_cnt == CNT_W'(MAX - 1)) ? '0 : r_pwm_cnt + CNT_W'(1);
            end
            if (w_period_end) begin
                r_slew <= w_step ? '0 : r_slew + SLEW_W'(1);
            end
        end
    end

    // One extra bit keeps the up-step from wrapping past MAX and the down-step from going negative.
    assign w_duty_x    = {1'b0, r_duty};
    assign w_target_x  = {1'b0, w_target};
    assign w_up_sum    = w_duty_x + (CNT_W + 1)'(STEP);
    assign w_up_sat    = (w_up_sum > (CNT_W + 1)'(MAX)) ? (CNT_W + 1)'(MAX) : w_up_sum;
    assign w_up_clamp  = (w_up_sat > w_target_x) ? w_target_x : w_up_sat;
    assign w_dn_diff   = (w_duty_x >= (CNT_W + 1)'(STEP)) ? w_duty_x - (CNT_W + 1)'(STEP) : '0;
    assign w_dn_clamp  = (w_dn_diff < w_target_x) ? w_target_x : w_dn_diff;
    assign w_duty_next = (w_target > r_duty) ? CNT_W'(w_up_clamp) :
                         (w_target < r_duty) ? CNT_W'(w_dn_clamp) : r_duty;

    // Ramp FSM: direction is re-decided at every step, so a target reversal turns the ramp around at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_duty   <= '0;
            r_pwm_hi <= 1'b0;
            r_fault  <= 1'b0;
        end else if (!ena) begin
            r_state  <= IDLE;
            r_duty   <= '0;
            r_pwm_hi <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_fault  <= multi_flag(lvl_30, lvl_50, lvl_100);
            r_pwm_hi <= (r_pwm_cnt < r_duty);
            case (r_state)
                IDLE: begin
                    if (w_target != '0) begin
                        r_state <= RAMP_UP;
                    end
                end
                RAMP_UP, RAMP_DN: begin
                    if (w_step) begin
                        r_duty <= w_duty_next;
                        if (w_duty_next == w_target) begin
                            r_state <= (w_target == '0) ? IDLE : HOLD;
                        end else if (w_target > r_duty) begin
                            r_state <= RAMP_UP;
                        end else begin
                            r_state <= RAMP_DN;
                        end
                    end else if (r_duty == w_target) begin
                        r_state <= (w_target == '0) ? IDLE : HOLD;
                    end
                end
                HOLD: begin
                    if (w_target > r_duty) begin
                        r_state <= RAMP_UP;
                    end else if (w_target < r_duty) begin
                        r_state <= RAMP_DN;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign duty_cur    = r_duty;
    assign busy        = (r_state == RAMP_UP) || (r_state == RAMP_DN);
    assign fault_multi = r_fault;

`ifdef DEADTIME_EN
    logic w_dt_hi;
    logic w_dt_lo;

    pwm_deadtime_gen #(
        .DEAD_CYC (DEAD_CYC)
    ) u_deadtime (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (~ena),
        .i_pwm (r_pwm_hi),
        .o_hi  (w_dt_hi),
        .o_lo  (w_dt_lo)
    );

    assign pwm_hi = w_dt_hi;
    assign pwm_lo = w_dt_lo;
`else
    // Without dead-time generation the low side is simply held off.
    assign pwm_hi = r_pwm_hi;
    assign pwm_lo = 1'b0 & (DEAD_CYC < 0);
`endif

endmodule

// File: tb/tb_pwm_duty_ramp_driver.sv
// Self-checking bench for pwm_duty_ramp_driver: flag/fault vector table plus duty-ramp scoreboard.
module tb_pwm_duty_ramp_driver;

   localparam int CNT_W      = 8;
   localparam int PRESC_DIV  = 2;
   localparam int SLEW_PER   = 1;
   localparam int STEP       = 16;
   localparam int DUTY_30    = 77;
   localparam int DUTY_50    = 128;
   localparam int DEAD_CYC   = 4;
   localparam int MAXD       = 255;
   localparam int PERIOD_CLK = MAXD * PRESC_DIV * SLEW_PER;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             ena = 1'b0;
   logic             lvl_30 = 1'b0;
   logic             lvl_50 = 1'b0;
   logic             lvl_100 = 1'b0;
   logic             pwm_hi;
   logic             pwm_lo;
   logic [CNT_W-1:0] duty_cur;
   logic             busy;
   logic             fault_multi;

   pwm_duty_ramp_driver #(
      .CNT_W     (CNT_W),
      .PRESC_DIV (PRESC_DIV),
      .SLEW_PER  (SLEW_PER),
      .STEP      (STEP),
      .DUTY_30   (DUTY_30),
      .DUTY_50   (DUTY_50),
      .DEAD_CYC  (DEAD_CYC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .lvl_30      (lvl_30),
      .lvl_50      (lvl_50),
      .lvl_100     (lvl_100),
      .pwm_hi      (pwm_hi),
      .pwm_lo      (pwm_lo),
      .duty_cur    (duty_cur),
      .busy        (busy),
      .fault_multi (fault_multi)
   );

   // 100 MHz free-running clock.
   always #5 clk = ~clk;

   typedef struct {
      logic l30;
      logic l50;
      logic l100;
      int   expFault;
      int   expBusy;
   } vec_t;

   typedef struct {
      int duty;
      bit checkGap;
   } sbItem_t;

   int      passCount = 0;
   int      checkCount = 0;
   int      cycleCount = 0;
   int      lastDuty = 0;
   int      lastChangeCycle = 0;
   bit      sbEnable = 1'b0;
   sbItem_t sbQueue[$];
   sbItem_t monItem;
   vec_t    vecs[9];

   // Free-running cycle stamp used to measure spacing between duty steps.
   always @(posedge clk) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual == expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Scoreboard monitor: each duty change must match the next queued value, one step period after the last.
   always @(negedge clk) begin
      if (sbEnable && (int'(duty_cur) != lastDuty)) begin
         if (sbQueue.size() == 0) begin
            checkOutput("sb_unexpected_change", int'(duty_cur), lastDuty);
         end else begin
            monItem = sbQueue.pop_front();
            checkOutput("sb_duty", int'(duty_cur), monItem.duty);
            if (monItem.checkGap) begin
               checkOutput("sb_step_gap", cycleCount - lastChangeCycle, PERIOD_CLK);
            end
         end
         lastChangeCycle = cycleCount;
      end
      lastDuty = int'(duty_cur);
   end

   function automatic int modelStep(input int d, input int t);
      int n;
      n = d;
      if (t > d) begin
         n = d + STEP;
         if (n > MAXD) n = MAXD;
         if (n > t) n = t;
      end else if (t < d) begin
         n = d - STEP;
         if (n < 0) n = 0;
         if (n < t) n = t;
      end
      return n;
   endfunction

   task automatic pushRamp(input int startDuty, input int target, input bit firstGap);
      int d;
      bit first;
      d = startDuty;
      first = 1'b1;
      while (d != target) begin
         d = modelStep(d, target);
         sbQueue.push_back('{duty: d, checkGap: first ? firstGap : 1'b1});
         first = 1'b0;
      end
   endtask

   task automatic pushOne(input int d, input bit gap);
      sbQueue.push_back('{duty: d, checkGap: gap});
   endtask

   task automatic waitDrain(input string name, input int budget);
      int n;
      n = 0;
      while ((sbQueue.size() != 0) && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, sbQueue.size(), 0);
      sbQueue.delete();
   endtask

   task automatic observe(input int n, output int hiCount, output int toggles, output int loCount);
      logic prev;
      hiCount = 0;
      toggles = 0;
      loCount = 0;
      @(negedge clk);
      prev = pwm_hi;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (pwm_hi) hiCount++;
         if (pwm_lo) loCount++;
         if (pwm_hi != prev) toggles++;
         prev = pwm_hi;
      end
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      @(negedge clk);
      lvl_30  = v.l30;
      lvl_50  = v.l50;
      lvl_100 = v.l100;
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_fault", idx), int'(fault_multi), v.expFault);
      checkOutput($sformatf("vec%0d_busy", idx), int'(busy), v.expBusy);
   endtask

`ifdef DEADTIME_EN
   int   bothHigh;
   int   minGap;
   int   lastFall;
   logic prevHi;
   logic prevLo;
`endif

   // Hard stop in case a bounded wait was mis-sized.
   initial begin
      #950000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int hiCount;
      int toggles;
      int loCount;
      int n;

      vecs[0] = '{1'b0, 1'b0, 1'b0, 0, 0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 0, 1};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 1, 1};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 0, 1};
      vecs[4] = '{1'b0, 1'b1, 1'b1, 1, 1};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 1, 1};
      vecs[6] = '{1'b0, 1'b0, 1'b1, 0, 1};
      vecs[7] = '{1'b1, 1'b0, 1'b1, 1, 1};
      vecs[8] = '{1'b0, 1'b0, 1'b0, 0, 0};

      $display("[TB] reset and idle");
      ena = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rst_duty", int'(duty_cur), 0);
      checkOutput("rst_pwm_hi", int'(pwm_hi), 0);
      checkOutput("rst_pwm_lo", int'(pwm_lo), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_fault", int'(fault_multi), 0);
      rst_n = 1'b1;
      observe(600, hiCount, toggles, loCount);
      checkOutput("idle_pwm_toggles", toggles, 0);
      checkOutput("idle_pwm_high", hiCount, 0);
      checkOutput("idle_duty", int'(duty_cur), 0);

      $display("[TB] flag/fault vector table");
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i], i);
      end

      $display("[TB] lvl_30 ramp");
      @(negedge clk);
      sbEnable = 1'b1;
      lvl_30 = 1'b1;
      pushOne(16, 1'b0);
      pushOne(32, 1'b1);
      pushOne(48, 1'b1);
      pushOne(64, 1'b1);
      pushOne(77, 1'b1);
      waitDrain("ramp30_drain", 6 * PERIOD_CLK + 100);
      repeat (2) @(negedge clk);
      checkOutput("ramp30_hold_busy", int'(busy), 0);
      checkOutput("ramp30_hold_duty", int'(duty_cur), 77);
      observe(PERIOD_CLK, hiCount, toggles, loCount);
`ifndef DEADTIME_EN
      checkOutput("duty77_high_cycles", hiCount, 77 * PRESC_DIV);
`endif

      $display("[TB] asynchronous reset mid-period");
      sbEnable = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("arst_duty", int'(duty_cur), 0);
      checkOutput("arst_pwm_hi", int'(pwm_hi), 0);
      checkOutput("arst_busy", int'(busy), 0);
      lvl_30 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] lvl_100 saturation and ramp down");
      sbEnable = 1'b1;
      lvl_100 = 1'b1;
      pushRamp(0, MAXD, 1'b0);
      waitDrain("ramp100_drain", 17 * PERIOD_CLK + 100);
      observe(600, hiCount, toggles, loCount);
      checkOutput("full_pwm_high", hiCount, 600);
      checkOutput("full_pwm_toggles", toggles, 0);
`ifndef DEADTIME_EN
      checkOutput("nodt_pwm_lo_high", loCount, 0);
`endif
      @(negedge clk);
      lvl_100 = 1'b0;
      pushRamp(MAXD, 0, 1'b0);
      waitDrain("rampdown_drain", 17 * PERIOD_CLK + 100);
      repeat (2) @(negedge clk);
      checkOutput("rampdown_busy", int'(busy), 0);
      observe(600, hiCount, toggles, loCount);
      checkOutput("zero_pwm_high", hiCount, 0);

      $display("[TB] multiple flags");
      @(negedge clk);
      lvl_30 = 1'b1;
      lvl_50 = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("multi_fault_set", int'(fault_multi), 1);
      pushRamp(0, DUTY_50, 1'b0);
      n = 0;
      while ((sbQueue.size() > 5) && (n < 4 * PERIOD_CLK + 100)) begin
         @(negedge clk);
         n++;
      end
      checkOutput("multi_partial_ramp", (sbQueue.size() <= 5) ? 1 : 0, 1);
      @(negedge clk);
      lvl_30 = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("multi_fault_clear", int'(fault_multi), 0);
      waitDrain("multi_drain", 8 * PERIOD_CLK + 100);
      checkOutput("multi_hold_duty", int'(duty_cur), DUTY_50);

      $display("[TB] enable drop");
      sbEnable = 1'b0;
      @(negedge clk);
      ena = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("ena_off_duty", int'(duty_cur), 0);
      checkOutput("ena_off_pwm_hi", int'(pwm_hi), 0);
      checkOutput("ena_off_busy", int'(busy), 0);
      @(negedge clk);
      ena = 1'b1;
      n = 0;
      @(negedge clk);
      while ((duty_cur == '0) && (n < PERIOD_CLK + 100)) begin
         @(negedge clk);
         n++;
      end
      checkOutput("ena_restart_first_step", int'(duty_cur), STEP);
      repeat (PERIOD_CLK - 1) @(negedge clk);
      ena = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("ena_wins_over_step", int'(duty_cur), 0);
      checkOutput("ena_wins_busy", int'(busy), 0);
      @(negedge clk);
      lvl_50 = 1'b0;
      ena = 1'b1;
      @(negedge clk);

      $display("[TB] reversal mid-ramp");
      sbEnable = 1'b1;
      lvl_50 = 1'b1;
      pushOne(16, 1'b0);
      pushOne(32, 1'b1);
      pushOne(48, 1'b1);
      pushOne(64, 1'b1);
      waitDrain("rev_up_drain", 5 * PERIOD_CLK + 100);
      lvl_50 = 1'b0;
      pushOne(48, 1'b1);
      pushOne(32, 1'b1);
      pushOne(16, 1'b1);
      pushOne(0, 1'b1);
      n = 0;
      while ((sbQueue.size() > 3) && (n < PERIOD_CLK + 100)) begin
         @(negedge clk);
         n++;
      end
      checkOutput("rev_first_down_step", int'(duty_cur), 48);
      checkOutput("rev_busy_down", int'(busy), 1);
      waitDrain("rev_down_drain", 4 * PERIOD_CLK + 100);
      repeat (2) @(negedge clk);
      checkOutput("rev_idle_busy", int'(busy), 0);

`ifdef DEADTIME_EN
      $display("[TB] dead-time at duty 128");
      lvl_50 = 1'b1;
      pushRamp(0, DUTY_50, 1'b0);
      waitDrain("dt_drain", 9 * PERIOD_CLK + 100);
      bothHigh = 0;
      minGap = 1000000;
      lastFall = -1000000;
      @(negedge clk);
      prevHi = pwm_hi;
      prevLo = pwm_lo;
      loCount = 0;
      for (int i = 0; i < 2 * PERIOD_CLK + 50; i++) begin
         @(negedge clk);
         if (pwm_hi && pwm_lo) bothHigh++;
         if (pwm_lo) loCount++;
         if ((prevHi && !pwm_hi) || (prevLo && !pwm_lo)) lastFall = i;
         if (((!prevHi && pwm_hi) || (!prevLo && pwm_lo)) && ((i - lastFall) < minGap)) begin
            minGap = i - lastFall;
         end
         prevHi = pwm_hi;
         prevLo = pwm_lo;
      end
      checkOutput("dt_both_high_cycles", bothHigh, 0);
      checkOutput("dt_min_gap_ge_dead", (minGap >= DEAD_CYC) ? 1 : 0, 1);
      checkOutput("dt_lo_active", (loCount > 0) ? 1 : 0, 1);
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
